qos_wrr_arbiter: RTL and testbench

QOS_WRR_ARBITER -- requirements
Module: qos_wrr_arbiter

---
 rtl/qos_wrr_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_qos_wrr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_wrr_arbiter.sv
// QoS weighted-round-robin packet arbiter with per-level credits, packet lock and aging override.
// Optional statistics (stat_pkts, max_wait) are built only when QOS_ARB_STATS_EN is defined.
module qos_wrr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned QOS_LEVELS = 4,
  parameter int unsigned WEIGHT_W   = 4,
  parameter int unsigned AGE_W      = 8,
  localparam int unsigned QW        = $clog2(QOS_LEVELS),
  localparam int unsigned IW        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*QW-1:0]        req_qos,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic                         out_ready,
  input  logic [QOS_LEVELS*WEIGHT_W-1:0] cfg_weight,
  input  logic [AGE_W-1:0]             aging_threshold,
  input  logic                         fairness_enable,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         locked,
  output logic [NUM_REQ-1:0]           starved,
  output logic [QOS_LEVELS*32-1:0]     stat_pkts,
  output logic [AGE_W-1:0]             max_wait
);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [QW-1:0]       olvl_q, olvl_d;
  logic                ofree_q, ofree_d;
  logic [WEIGHT_W-1:0] credit_q [QOS_LEVELS];
  logic [WEIGHT_W-1:0] credit_d [QOS_LEVELS];
  logic [IW-1:0]       ptr_q    [QOS_LEVELS];
  logic [IW-1:0]       ptr_d    [QOS_LEVELS];
  logic [AGE_W-1:0]    age_q    [NUM_REQ];
  logic [AGE_W-1:0]    age_d    [NUM_REQ];

  logic [QW-1:0]         req_lvl [NUM_REQ];
  logic [QOS_LEVELS-1:0] lvl_req;
  logic [NUM_REQ-1:0]    starved_c, grant_c;
  logic                  cred_ok, rel_ok, rr_found, aged_found;
  logic [QW-1:0]         cred_lvl, rel_lvl, top_lvl, sel_lvl, win_lvl;
  logic [IW-1:0]         rr_win, aged_win, win, idx;
  logic                  free, reload, xfer, done;

  // Out-of-range QoS codes (non power-of-two level counts) fold onto the top level.
  always_comb begin
    lvl_req   = '0;
    starved_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_lvl[i] = (32'(req_qos[i*QW +: QW]) >= QOS_LEVELS) ? QW'(QOS_LEVELS - 1)
                                                           : req_qos[i*QW +: QW];
      if (req[i]) lvl_req[req_lvl[i]] = 1'b1;
      starved_c[i] = req[i] && (aging_threshold != '0) && (age_q[i] >= aging_threshold);
    end
  end

  always_comb begin
    cred_ok  = 1'b0;
    rel_ok   = 1'b0;
    cred_lvl = '0;
    rel_lvl  = '0;
    top_lvl  = '0;
    for (int unsigned l = 0; l < QOS_LEVELS; l++) begin
      if (lvl_req[l]) begin
        top_lvl = QW'(l);
        if (credit_q[l] != '0) begin
          cred_ok  = 1'b1;
          cred_lvl = QW'(l);
        end
        if (cfg_weight[l*WEIGHT_W +: WEIGHT_W] != '0) begin
          rel_ok  = 1'b1;
          rel_lvl = QW'(l);
        end
      end
    end
    sel_lvl = cred_ok ? cred_lvl : (rel_ok ? rel_lvl : top_lvl);

    rr_found = 1'b0;
    rr_win   = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(ptr_q[sel_lvl]) + k) % NUM_REQ);
      if (!rr_found && req[idx] && (req_lvl[idx] == sel_lvl)) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end

    aged_found = 1'b0;
    aged_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!aged_found && starved_c[i]) begin
        aged_found = 1'b1;
        aged_win   = IW'(i);
      end
    end
  end

  // A packet picked by an aged override or a reload cycle is "free": it never decrements credit.
  always_comb begin
    grant_c = '0;
    win     = '0;
    win_lvl = '0;
    free    = 1'b0;
    reload  = 1'b0;
    if (state_q == LOCKED) begin
      win              = owner_q;
      win_lvl          = olvl_q;
      free             = ofree_q;
      grant_c[owner_q] = req[owner_q];
    end else if (fairness_enable && aged_found) begin
      win               = aged_win;
      win_lvl           = req_lvl[aged_win];
      free              = 1'b1;
      grant_c[aged_win] = 1'b1;
    end else if (|req) begin
      win             = rr_win;
      win_lvl         = sel_lvl;
      reload          = !cred_ok;
      free            = !cred_ok;
      grant_c[rr_win] = 1'b1;
    end
    xfer = (|grant_c) && out_ready;
    done = xfer && req_last[win];
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    olvl_d   = olvl_q;
    ofree_d  = ofree_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    if (state_q == LOCKED) begin
      if (!req[owner_q] || done) state_d = UNLOCKED;
    end else if (xfer && !req_last[win]) begin
      state_d = LOCKED;
      owner_d = win;
      olvl_d  = win_lvl;
      ofree_d = free;
    end
    if (reload) begin
      for (int unsigned l = 0; l < QOS_LEVELS; l++) credit_d[l] = cfg_weight[l*WEIGHT_W +: WEIGHT_W];
    end
    if (done) begin
      ptr_d[win_lvl] = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      if (!free && (credit_d[win_lvl] != '0)) credit_d[win_lvl] = credit_d[win_lvl] - 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!req[i] || (done && (win == IW'(i))))  age_d[i] = '0;
      else if (xfer && (win == IW'(i)))          age_d[i] = age_q[i];
      else if (age_q[i] != '1)                   age_d[i] = age_q[i] + 1'b1;
      else                                       age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      olvl_q  <= '0;
      ofree_q <= 1'b0;
      for (int unsigned l = 0; l < QOS_LEVELS; l++) begin
        credit_q[l] <= '0;
        ptr_q[l]    <= '0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      olvl_q   <= olvl_d;
      ofree_q  <= ofree_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      age_q    <= age_d;
    end
  end

  assign grant   = rst_n ? grant_c : '0;
  assign locked  = rst_n && (state_q == LOCKED);
  assign starved = rst_n ? starved_c : '0;

`ifdef QOS_ARB_STATS_EN
  logic [31:0] stat_q [QOS_LEVELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < QOS_LEVELS; l++) stat_q[l] <= '0;
    end else if (done) begin
      stat_q[win_lvl] <= stat_q[win_lvl] + 32'd1;
    end
  end

  always_comb begin
    stat_pkts = '0;
    max_wait  = '0;
    for (int unsigned l = 0; l < QOS_LEVELS; l++) stat_pkts[l*32 +: 32] = stat_q[l];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (age_q[i] > max_wait)) max_wait = age_q[i];
    end
    if (!rst_n) max_wait = '0;
  end
`else
  assign stat_pkts = '0;
  assign max_wait  = '0;
`endif

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Bench for qos_wrr_arbiter: directed scenarios with literal expectations plus a
// per-cycle reference model of the arbitration rules.
module tb_qos_wrr_arbiter;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int WW = 4;
  localparam int AW = 8;
  localparam int QW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_last, grant, starved;
  logic [N*QW-1:0] req_qos;
  logic            out_ready, fairness_enable, locked;
  logic [L*WW-1:0] cfg_weight;
  logic [AW-1:0]   aging_threshold, max_wait;
  logic [L*32-1:0] stat_pkts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qos_wrr_arbiter #(.NUM_REQ(N), .QOS_LEVELS(L), .WEIGHT_W(WW), .AGE_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_qos(req_qos), .req_last(req_last),
    .out_ready(out_ready), .cfg_weight(cfg_weight), .aging_threshold(aging_threshold),
    .fairness_enable(fairness_enable), .grant(grant), .locked(locked), .starved(starved),
    .stat_pkts(stat_pkts), .max_wait(max_wait)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  bit          m_locked, m_free;
  int          m_owner, m_lvl;
  int          m_cred [L];
  int          m_ptr  [L];
  int          m_age  [N];
  int unsigned m_stat [L];

  function automatic int qos_of(input int i);
    return int'(req_qos[i*QW +: QW]);
  endfunction

  function automatic int wt(input int l);
    return int'(cfg_weight[l*WW +: WW]);
  endfunction

  task automatic m_reset();
    m_locked = 0; m_free = 0; m_owner = 0; m_lvl = 0;
    for (int l = 0; l < L; l++) begin m_cred[l] = 0; m_ptr[l] = 0; m_stat[l] = 0; end
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  initial begin : compare
    int win, lvl, best, hi, hiw, j, mw;
    bit free, reload, xfer, done, lreq;
    logic [N-1:0]    exp_g, exp_st;
    logic [L*32-1:0] exp_stat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset();
        chk("rst_grant", grant, 0);
        chk("rst_locked", locked, 0);
        chk("rst_starved", starved, 0);
        chk("rst_max_wait", max_wait, 0);
        chk("rst_stat", stat_pkts, 0);
      end else begin
        win = -1; lvl = 0; free = 0; reload = 0; exp_g = '0; exp_st = '0;
        for (int i = 0; i < N; i++)
          exp_st[i] = req[i] && (aging_threshold != 0) && (m_age[i] >= int'(aging_threshold));
        if (m_locked) begin
          if (req[m_owner]) win = m_owner;
          lvl = m_lvl; free = m_free;
        end else if (fairness_enable && exp_st != 0) begin
          for (int i = N - 1; i >= 0; i--) if (exp_st[i]) win = i;
          lvl = qos_of(win); free = 1;
        end else if (req != 0) begin
          best = -1; hi = -1; hiw = -1;
          for (int l = 0; l < L; l++) begin
            lreq = 0;
            for (int i = 0; i < N; i++) if (req[i] && qos_of(i) == l) lreq = 1;
            if (lreq) begin
              hi = l;
              if (m_cred[l] > 0) best = l;
              if (wt(l) > 0) hiw = l;
            end
          end
          if (best >= 0) lvl = best;
          else begin reload = 1; free = 1; lvl = (hiw >= 0) ? hiw : hi; end
          for (int k = 0; k < N; k++) begin
            j = (m_ptr[lvl] + k) % N;
            if (win < 0 && req[j] && qos_of(j) == lvl) win = j;
          end
        end
        if (win >= 0) exp_g[win] = 1'b1;
        mw = 0; exp_stat = '0;
`ifdef QOS_ARB_STATS_EN
        for (int i = 0; i < N; i++) if (req[i] && m_age[i] > mw) mw = m_age[i];
        for (int l = 0; l < L; l++) exp_stat[l*32 +: 32] = m_stat[l];
`endif
        chk("grant", grant, exp_g);
        chk("locked", locked, m_locked);
        chk("starved", starved, exp_st);
        chk("max_wait", max_wait, mw);
        chk("stat_pkts", stat_pkts, exp_stat);

        xfer = (win >= 0) && out_ready;
        done = xfer && req_last[win];
        for (int i = 0; i < N; i++) begin
          if (!req[i] || (done && win == i)) m_age[i] = 0;
          else if (!(xfer && win == i) && m_age[i] < 255) m_age[i]++;
        end
        if (reload) for (int l = 0; l < L; l++) m_cred[l] = wt(l);
        if (done) begin
          m_ptr[lvl] = (win + 1) % N;
          if (!free && m_cred[lvl] > 0) m_cred[lvl]--;
          m_stat[lvl]++;
        end
        if (m_locked) begin
          if (!req[m_owner] || done) m_locked = 0;
        end else if (xfer && !req_last[win]) begin
          m_locked = 1; m_owner = win; m_lvl = lvl; m_free = free;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] last, input logic rdy);
    req = r; req_last = last; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply('0, '0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [N-1:0] s1_seq [9];
    logic         s2_rdy [4];
    logic         s2_last [4];
    logic         s2_lk [4];
    rst_n = 1'b0; req = '0; req_last = '0; req_qos = '0; out_ready = 1'b1;
    cfg_weight = '0; aging_threshold = '0; fairness_enable = 1'b0;

    // Weights 1, req0/1 at level 3, req2/3 at level 0, single-beat packets
    do_reset();
    cfg_weight = 16'h1111; req_qos = 8'h0F;
    s1_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    apply(4'hF, 4'hF, 1'b1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("wrr_seq%0d", c), grant, s1_seq[c]);
      tick();
    end

    // 3-beat packet from req 2 with out_ready 1,0,1,1
    do_reset();
    req_qos = 8'h10;
    s2_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1};
    s2_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    s2_lk   = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 4; c++) begin
      apply(4'b0100, s2_last[c] ? 4'b0100 : 4'b0000, s2_rdy[c]);
      @(negedge clk);
      chk($sformatf("pkt_grant%0d", c), grant, 4'b0100);
      chk($sformatf("pkt_locked%0d", c), locked, s2_lk[c]);
      tick();
    end
    apply('0, '0, 1'b1);
    @(negedge clk);
    chk("pkt_unlock", locked, 0);
    tick();

    // Aging: req0 at level 0 (weight 0) behind continuous level-3 traffic
    do_reset();
    cfg_weight = 16'h1000; req_qos = 8'h0C; aging_threshold = 8'd5; fairness_enable = 1'b1;
    apply(4'b0011, 4'b0011, 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("age_grant%0d", c), grant, (c == 5) ? 4'b0001 : 4'b0010);
      chk($sformatf("age_starved%0d", c), starved[0], c == 5);
      tick();
    end
    aging_threshold = '0; fairness_enable = 1'b0;

    // Owner aborts mid-packet
    do_reset();
    cfg_weight = 16'h1111; req_qos = 8'h08;
    apply(4'b0010, 4'b0000, 1'b1);
    @(negedge clk); chk("abort_g0", grant, 4'b0010); tick();
    @(negedge clk); chk("abort_lk1", locked, 1); chk("abort_g1", grant, 4'b0010); tick();
    apply('0, '0, 1'b1);
    @(negedge clk); chk("abort_g2", grant, 0); chk("abort_lk2", locked, 1); tick();
    @(negedge clk); chk("abort_lk3", locked, 0); chk("abort_stat", stat_pkts, 0); tick();

    // Reset while locked, then arbitration restarts at pointer 0
    do_reset();
    cfg_weight = 16'h2222; req_qos = 8'h55;
    apply(4'hF, 4'hF, 1'b1);
    @(negedge clk); chk("rl_g0", grant, 4'b0001); tick();
    apply(4'hF, 4'h0, 1'b1);
    @(negedge clk); chk("rl_g1", grant, 4'b0010); tick();
    @(negedge clk); chk("rl_lk", locked, 1); tick();
    rst_n = 1'b0;
    #1;
    chk("rl_rst_grant", grant, 0);
    chk("rl_rst_locked", locked, 0);
    chk("rl_rst_starved", starved, 0);
    chk("rl_rst_maxw", max_wait, 0);
    chk("rl_rst_stat", stat_pkts, 0);
    tick();
    tick();
    rst_n = 1'b1;
    apply(4'hF, 4'hF, 1'b1);
    @(negedge clk); chk("rl_first", grant, 4'b0001); tick();

    // Mixed traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req             = 4'($urandom);
      req_last        = 4'($urandom);
      out_ready       = ($urandom_range(0, 3) != 0);
      if (c % 8 == 0) req_qos = 8'($urandom);
      if (c % 16 == 0) cfg_weight = 16'($urandom);
      aging_threshold = 8'($urandom_range(0, 6));
      fairness_enable = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
